multicycle_controller: RTL

Parametrised multi-cycle successor to the single-cycle decode controller of the windowed-register CPU. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states rather than decoding in one step. It stalls on instruction-fetch and data-memory handshakes and flags illegal opcodes. It sits between the instruction register/PC logic and the datapath (ALU, register window file, data memory).

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/ctrl_decode.sv | 51 +++++
 rtl/multicycle_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle decode controller:
// opcode encodings, FSM states, instruction classes and ALU operation codes.
package ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_CMP   = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b1000;
    localparam logic [3:0] OP_IMM0  = 4'b1100;
    localparam logic [3:0] OP_IMM1  = 4'b1101;
    localparam logic [3:0] OP_IMM2  = 4'b1110;
    localparam logic [3:0] OP_IMM3  = 4'b1111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_JUMP,
        CL_CMP,
        CL_RTYPE,
        CL_IMM,
        CL_ILLEGAL
    } class_t;

    // Compare operation 7'b1000111, truncated when the ALU op field is narrower.
    function automatic logic [31:0] aluop_cmp(input int aluopw);
        if (aluopw >= 32) return 32'h0000_0047;
        return 32'h0000_0047 & ((32'd1 << aluopw) - 32'd1);
    endfunction

    // Immediate variants 1100..1111 select ALU ops 1<<1 .. 1<<4.
    function automatic logic [31:0] aluop_imm(input logic [1:0] sel);
        return 32'd1 << (32'(sel) + 32'd1);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU operation,
// immediate-operand select and illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int ALUOPW = 7
) (
    input  logic [OPW-1:0]    opcode,
    input  logic [ALUOPW-1:0] rfunc,
    output class_t            op_class,
    output logic [ALUOPW-1:0] aluop,
    output logic              immd_sel,
    output logic              illegal
);

    logic upper_set;

    // Any set bit above the decoded nibble makes the opcode illegal.
    assign upper_set = (opcode >> 4) != '0;

    always_comb begin
        op_class = CL_ILLEGAL;
        aluop    = '0;
        immd_sel = 1'b0;
        if (!upper_set) begin
            case (opcode[3:0])
                OP_LOAD:  op_class = CL_LOAD;
                OP_STORE: op_class = CL_STORE;
                OP_JUMP:  op_class = CL_JUMP;
                OP_CMP: begin
                    op_class = CL_CMP;
                    aluop    = ALUOPW'(aluop_cmp(ALUOPW));
                end
                OP_RTYPE: begin
                    op_class = CL_RTYPE;
                    aluop    = rfunc;
                end
                OP_IMM0, OP_IMM1, OP_IMM2, OP_IMM3: begin
                    op_class = CL_IMM;
                    aluop    = ALUOPW'(aluop_imm(opcode[1:0]));
                    immd_sel = 1'b1;
                end
                default: op_class = CL_ILLEGAL;
            endcase
        end
    end

    assign illegal = (op_class == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// fetch and data-memory handshake stalls and illegal-opcode detection.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int FUNCW  = 8,
    parameter int ALUOPW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [FUNCW-1:0]  func,
    input  logic              instr_valid,
    input  logic              mem_ready,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              jump,
    output logic              setWindow,
    output logic              mem_read,
    output logic              mem_write,
    output logic              immdSel,
    output logic              memOrALU,
    output logic              toWrite,
    output logic [ALUOPW-1:0] ALUop,
    output logic              busy,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [OPW-1:0]    op_q;
    logic [ALUOPW:0]   func_q;
    logic [OPW-1:0]    dec_op;
    class_t            dec_class;
    logic [ALUOPW-1:0] dec_aluop;
    logic              dec_immd;
    logic              dec_illegal;

    // The fields are not latched until the end of DECODE, so the
    // illegal check in that cycle looks at the live opcode.
    assign dec_op = (state_q == DECODE) ? opcode : op_q;

    ctrl_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) u_decode (
        .opcode   (dec_op),
        .rfunc    (func_q[ALUOPW-1:0]),
        .op_class (dec_class),
        .aluop    (dec_aluop),
        .immd_sel (dec_immd),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q   <= opcode;
                func_q <= func[ALUOPW:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        jump      = 1'b0;
        setWindow = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        immdSel   = 1'b0;
        memOrALU  = 1'b1;
        toWrite   = 1'b0;
        ALUop     = '0;
        illegal   = 1'b0;
        busy      = (state_q != FETCH);
        case (state_q)
            FETCH: begin
                if (instr_valid) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ALUop   = dec_aluop;
                immdSel = dec_immd;
                case (dec_class)
                    CL_JUMP: begin
                        jump    = 1'b1;
                        state_d = FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = MEM;
                    CL_IMM:            state_d = WB;
                    CL_RTYPE: begin
                        setWindow = func_q[ALUOPW];
                        state_d   = (func_q[ALUOPW -: 2] == 2'b00) ? WB : FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_read  = (dec_class == CL_LOAD);
                mem_write = (dec_class == CL_STORE);
                if (mem_ready) state_d = (dec_class == CL_LOAD) ? WB : FETCH;
            end
            WB: begin
                toWrite  = 1'b1;
                memOrALU = (dec_class != CL_LOAD);
                ALUop    = dec_aluop;
                immdSel  = dec_immd;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule
